vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port video/character BRAM inside the Ace core between two requesters: the video fetch engine (pixel side) and the Z80 CPU bus.
- Video has absolute priority; the CPU waits while video is fetching.
- Fixed 3-cycle read pipeline; one grant per cycle.
- Sits between the core's video generator, CPU memory decode and the BRAM, clocked from the 75 MHz RAM clock.

Parameters:
- ADDR_W, 10, BRAM address width (1K screen or charset bank)
- DATA_W, 8, data width
- STALL_W, 16, width of the CPU stall counters (saturating)

Ports:
- clkram  in  1  RAM clock (75 MHz); all logic rising-edge
- reset  in  1  asynchronous, active-high
- vid_req  in  1  single-cycle fetch strobe from video engine
- vid_addr  in  ADDR_W  fetch address, valid with vid_req
- vid_data  out  DATA_W  fetched byte
- vid_valid  out  1  one-cycle strobe, vid_data valid
- cpu_req  in  1  level; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  ADDR_W  stable while cpu_req
- cpu_wdata  in  DATA_W  stable while cpu_req
- cpu_rdata  out  DATA_W  read data
- cpu_ack  out  1  one-cycle completion strobe
- cpu_wait  out  1  cpu_req & ~cpu_ack, combinational; drives Z80 WAIT logic
- ram_addr  out  ADDR_W  registered BRAM address
- ram_we  out  1  registered BRAM write enable
- ram_wdata  out  DATA_W  registered BRAM write data
- ram_rdata  in  DATA_W  BRAM output; registered, 1-cycle latency
- stall_max  out  STALL_W  longest CPU wait observed since reset, in cycles

Behaviour:
- Reset values: vid_valid = 0, cpu_ack = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, vid_data = 0, cpu_rdata = 0, stall_max = 0, stall_cnt = 0, inflight = 0, pipeline tags = NONE.
- Arbitration in cycle t:
  - If vid_req: grant VID.
  - Else if cpu_req & ~inflight: grant CPU and set inflight.
  - Else: grant NONE.
- Pipeline for a grant in cycle t:
  - End of t: register ram_addr, ram_we (CPU write only), ram_wdata and tag0.
  - t+1: BRAM access; tag1 <= tag0.
  - t+2: ram_rdata valid; tag2 <= tag1.
  - End of t+2: VID tag loads vid_data <= ram_rdata. CPU read tag loads cpu_rdata.
  - During t+3: vid_valid or cpu_ack high for exactly one cycle.
  - Latency from request to strobe is 3 cycles for video, CPU reads and CPU writes alike.
- ram_we is high for exactly the single t+1 cycle of a CPU write grant; otherwise 0. A NONE grant leaves ram_addr unchanged and forces ram_we = 0.
- inflight clears in the same edge that raises cpu_ack. The CPU may issue the next request in the cycle after the ack; the earliest regrant is the cycle after cpu_req is seen again with inflight = 0.
- Simultaneous vid_req and eligible cpu_req: video wins and the CPU stays pending. Back-to-back vid_req blocks the CPU indefinitely; the CPU is never forced in.
- Stall counter:
  - stall_cnt increments (saturating at all-ones) each cycle cpu_req & ~inflight & ~grant_cpu.
  - It clears to 0 on a CPU grant.
  - On a CPU grant, stall_max <= max(stall_max, stall_cnt).
- Protocol edge cases:
  - cpu_req dropped before grant: no access, no ack.
  - cpu_req dropped after grant: the access completes and cpu_ack still pulses.
  - vid_req while the pipeline is full: always accepted, because the pipeline never backpressures.
- Reset asserted mid-operation: all in-flight accesses are discarded immediately and no vid_valid/cpu_ack is produced for them. A write in flight may or may not have reached the BRAM.
- vid_valid and cpu_ack can never both be high in the same cycle, since there is one grant per cycle.

Test Plan:
- Single video fetch: vid_req pulse at cycle 10, vid_addr = 0x05A, BRAM[0x05A] = 0x3C -> ram_addr = 0x05A during cycle 11; vid_valid high only in cycle 13 with vid_data = 0x3C.
- CPU write then read: write 0xA5 to 0x3FF, wait for ack, then read 0x3FF -> ram_we high for 1 cycle; each cpu_ack arrives 3 cycles after its grant; cpu_rdata = 0xA5; cpu_wait drops in the ack cycle.
- Contention: cpu_req raised in the same cycle as 4 consecutive vid_req pulses -> 4 vid_valid pulses in cycles t+3..t+6; CPU granted at t+4; cpu_ack at t+7; stall_max = 4.
- Starvation measurement: 100 consecutive vid_req cycles with the CPU pending, then idle -> CPU completes; stall_max = 100 and holds after a later 3-cycle stall.
- Reset mid-access: CPU read granted, reset asserted at grant+1 -> no cpu_ack, all outputs 0 immediately (asynchronous); after release, a retried read completes normally.
- Abandoned request: cpu_req high 1 cycle during vid_req, then dropped -> no ram access for the CPU, no cpu_ack, stall_cnt returns to 0 after the next grant.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port video/charset BRAM between the video fetch
// engine (absolute priority) and the Z80 CPU through a fixed 3-cycle read pipeline.
module vram_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int STALL_W = 16
) (
    input  logic               clkram,
    input  logic               reset,
    input  logic               vid_req,
    input  logic [ADDR_W-1:0]  vid_addr,
    output logic [DATA_W-1:0]  vid_data,
    output logic               vid_valid,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic               cpu_ack,
    output logic               cpu_wait,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_rdata,
    output logic [STALL_W-1:0] stall_max
);

    typedef enum logic [1:0] {
        TAG_NONE   = 2'd0,
        TAG_VID    = 2'd1,
        TAG_CPU_RD = 2'd2,
        TAG_CPU_WR = 2'd3
    } tag_t;

    tag_t               tag_grant_s;
    tag_t               tag0_r;
    tag_t               tag1_r;
    logic               grant_vid_s;
    logic               grant_cpu_s;
    logic               cpu_pend_s;
    logic               inflight_r;
    logic [STALL_W-1:0] stall_cnt_r;

    // Grant decode; cpu_req is still high during its ack cycle, so that cycle is not eligible
    always_comb begin
        cpu_pend_s  = cpu_req & ~inflight_r & ~cpu_ack;
        grant_vid_s = vid_req;
        grant_cpu_s = cpu_pend_s & ~vid_req;
        if (grant_vid_s) begin
            tag_grant_s = TAG_VID;
        end else if (grant_cpu_s) begin
            tag_grant_s = cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
        end else begin
            tag_grant_s = TAG_NONE;
        end
    end

    assign cpu_wait = cpu_req & ~cpu_ack;

    // Access pipeline: issue to BRAM, track tag, capture read data and raise strobes
    always_ff @(posedge clkram or posedge reset) begin
        if (reset) begin
            tag0_r     <= TAG_NONE;
            tag1_r     <= TAG_NONE;
            ram_addr   <= {ADDR_W{1'b0}};
            ram_we     <= 1'b0;
            ram_wdata  <= {DATA_W{1'b0}};
            vid_data   <= {DATA_W{1'b0}};
            cpu_rdata  <= {DATA_W{1'b0}};
            vid_valid  <= 1'b0;
            cpu_ack    <= 1'b0;
            inflight_r <= 1'b0;
        end else begin
            tag0_r <= tag_grant_s;
            tag1_r <= tag0_r;
            ram_we <= grant_cpu_s & cpu_we;
            if (grant_vid_s) begin
                ram_addr <= vid_addr;
            end else if (grant_cpu_s) begin
                ram_addr  <= cpu_addr;
                ram_wdata <= cpu_wdata;
            end
            // tag1_r names the access whose BRAM output is on ram_rdata this cycle
            if (tag1_r == TAG_VID) begin
                vid_data <= ram_rdata;
            end
            if (tag1_r == TAG_CPU_RD) begin
                cpu_rdata <= ram_rdata;
            end
            vid_valid <= (tag1_r == TAG_VID);
            cpu_ack   <= (tag1_r == TAG_CPU_RD) || (tag1_r == TAG_CPU_WR);
            if (grant_cpu_s) begin
                inflight_r <= 1'b1;
            end else if ((tag1_r == TAG_CPU_RD) || (tag1_r == TAG_CPU_WR)) begin
                inflight_r <= 1'b0;
            end
        end
    end

    // CPU stall measurement: current wait length and the worst seen since reset
    always_ff @(posedge clkram or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= {STALL_W{1'b0}};
            stall_max   <= {STALL_W{1'b0}};
        end else if (grant_cpu_s) begin
            stall_cnt_r <= {STALL_W{1'b0}};
            if (stall_cnt_r > stall_max) begin
                stall_max <= stall_cnt_r;
            end
        end else if (cpu_pend_s && (stall_cnt_r != {STALL_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(STALL_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised and directed bench for vram_arbiter against a cycle-numbered reference model
// built from the arbitration rules, with a behavioural BRAM and a shadow memory.
module tb_vram_arbiter;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 8;
    localparam int STALL_W = 16;

    logic               clkram = 1'b0;
    logic               reset;
    logic               vid_req;
    logic [ADDR_W-1:0]  vid_addr;
    logic [DATA_W-1:0]  vid_data;
    logic               vid_valid;
    logic               cpu_req;
    logic               cpu_we;
    logic [ADDR_W-1:0]  cpu_addr;
    logic [DATA_W-1:0]  cpu_wdata;
    logic [DATA_W-1:0]  cpu_rdata;
    logic               cpu_ack;
    logic               cpu_wait;
    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_we;
    logic [DATA_W-1:0]  ram_wdata;
    logic [DATA_W-1:0]  ram_rdata;
    logic [STALL_W-1:0] stall_max;

    logic               init_en;
    logic [ADDR_W-1:0]  init_addr;
    logic [DATA_W-1:0]  init_data;
    logic [DATA_W-1:0]  bram   [0:1023];
    logic [DATA_W-1:0]  shadow [0:1023];

    int checks = 0;
    int errors = 0;

    // Model state: absolute cycle number, last CPU grant, stall bookkeeping
    int   cyc = 0;
    int   last_cpu_grant = -100;
    int   wait_cnt = 0;
    int   smax = 0;
    int   smax_vis = 0;
    logic model_ack = 1'b0;
    logic              e_vv [16];
    logic              e_ack[16];
    logic              e_we [16];
    logic              e_av [16];
    logic              e_rv [16];
    logic [DATA_W-1:0] e_vd [16];
    logic [DATA_W-1:0] e_rd [16];
    logic [DATA_W-1:0] e_wd [16];
    logic [ADDR_W-1:0] e_addr[16];

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_W(STALL_W)) dut (
        .clkram(clkram), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .stall_max(stall_max)
    );

    always #5 clkram = ~clkram;

    // Behavioural BRAM: registered read, one-cycle latency, preload port used during reset
    always @(posedge clkram) begin
        if (init_en) bram[init_addr] <= init_data;
        else if (ram_we) bram[ram_addr] <= ram_wdata;
        ram_rdata <= bram[ram_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            e_vv[i] = 1'b0; e_ack[i] = 1'b0; e_we[i] = 1'b0; e_av[i] = 1'b0; e_rv[i] = 1'b0;
        end
        last_cpu_grant = -100;
        wait_cnt = 0;
        smax = 0;
        model_ack = 1'b0;
    endtask

    task automatic check_zero();
        check_eq("rst_vid_valid", 32'(vid_valid), 32'd0);
        check_eq("rst_cpu_ack",   32'(cpu_ack),   32'd0);
        check_eq("rst_ram_we",    32'(ram_we),    32'd0);
        check_eq("rst_ram_addr",  32'(ram_addr),  32'd0);
        check_eq("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check_eq("rst_vid_data",  32'(vid_data),  32'd0);
        check_eq("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check_eq("rst_stall_max", 32'(stall_max), 32'd0);
        check_eq("rst_cpu_wait",  32'(cpu_wait),  32'd0);
    endtask

    // One clock cycle: drive inputs, predict from the rules, then compare at the falling edge
    task automatic cycle(input logic vr, input logic [9:0] va, input logic cr,
                         input logic cw, input logic [9:0] ca, input logic [7:0] cd);
        int s; int s1; int s3; logic cpu_ok;
        @(posedge clkram); #1;
        cyc++;
        vid_req = vr; vid_addr = va; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        smax_vis = smax;
        s = cyc % 16; s1 = (cyc + 1) % 16; s3 = (cyc + 3) % 16;
        cpu_ok = cr && (cyc >= last_cpu_grant + 4);
        if (vr) begin
            e_vv[s3] = 1'b1; e_vd[s3] = shadow[va]; e_av[s1] = 1'b1; e_addr[s1] = va;
            if (cpu_ok && wait_cnt < 65535) wait_cnt++;
        end else if (cpu_ok) begin
            last_cpu_grant = cyc;
            if (wait_cnt > smax) smax = wait_cnt;
            wait_cnt = 0;
            e_ack[s3] = 1'b1; e_av[s1] = 1'b1; e_addr[s1] = ca;
            if (cw) begin
                e_we[s1] = 1'b1; e_wd[s1] = cd; shadow[ca] = cd;
            end else begin
                e_rv[s3] = 1'b1; e_rd[s3] = shadow[ca];
            end
        end
        @(negedge clkram);
        model_ack = e_ack[s];
        check_eq("vid_valid", 32'(vid_valid), 32'(e_vv[s]));
        if (e_vv[s]) check_eq("vid_data", 32'(vid_data), 32'(e_vd[s]));
        check_eq("cpu_ack", 32'(cpu_ack), 32'(e_ack[s]));
        if (e_rv[s]) check_eq("cpu_rdata", 32'(cpu_rdata), 32'(e_rd[s]));
        check_eq("ram_we", 32'(ram_we), 32'(e_we[s]));
        if (e_we[s]) check_eq("ram_wdata", 32'(ram_wdata), 32'(e_wd[s]));
        if (e_av[s]) check_eq("ram_addr", 32'(ram_addr), 32'(e_addr[s]));
        check_eq("cpu_wait", 32'(cpu_wait), 32'(cr & ~e_ack[s]));
        check_eq("stall_max", 32'(stall_max), 32'(smax_vis));
        e_vv[s] = 1'b0; e_ack[s] = 1'b0; e_we[s] = 1'b0; e_av[s] = 1'b0; e_rv[s] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 8'h0);
    endtask

    // CPU transaction behind nvid back-to-back video fetches, held until the model's ack
    task automatic cpu_run(input logic cw, input logic [9:0] ca, input logic [7:0] cd, input int nvid);
        int k;
        for (int i = 0; i < nvid; i++) cycle(1'b1, 10'(i * 7), 1'b1, cw, ca, cd);
        k = 0;
        do begin
            cycle(1'b0, 10'h0, 1'b1, cw, ca, cd);
            k++;
        end while (!model_ack && k < 20);
    endtask

    logic              cpu_active;
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    int                start_cyc;

    initial begin
        reset = 1'b1; vid_req = 1'b0; vid_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; init_en = 1'b1; init_addr = '0; init_data = '0;
        model_clear();
        for (int i = 0; i < 1024; i++) begin
            @(negedge clkram);
            init_addr = 10'(i);
            init_data = (i == 'h05A) ? 8'h3C : 8'($urandom);
            shadow[i] = init_data;
        end
        @(negedge clkram);
        init_en = 1'b0;
        check_zero();
        reset = 1'b0;
        idle(3);

        // single video fetch of 0x05A holding 0x3C
        cycle(1'b1, 10'h05A, 1'b0, 1'b0, 10'h0, 8'h0);
        idle(4);
        check_eq("vid_fetch_data", 32'(vid_data), 32'h3C);

        // CPU write then read back of 0x3FF
        cpu_run(1'b1, 10'h3FF, 8'hA5, 0);
        cpu_run(1'b0, 10'h3FF, 8'h00, 0);
        idle(1);
        check_eq("cpu_readback", 32'(cpu_rdata), 32'hA5);

        // contention: CPU raised with 4 consecutive video fetches
        cpu_run(1'b0, 10'h123, 8'h00, 4);
        idle(1);
        check_eq("stall_max_contention", 32'(stall_max), 32'd4);

        // starvation: 100 video cycles, then a shorter 3-cycle stall
        cpu_run(1'b1, 10'h2AA, 8'h5B, 100);
        idle(1);
        check_eq("stall_max_starve", 32'(stall_max), 32'd100);
        cpu_run(1'b0, 10'h2AA, 8'h00, 3);
        idle(1);
        check_eq("stall_max_hold", 32'(stall_max), 32'd100);

        // reset one cycle after a CPU read grant
        cycle(1'b0, 10'h0, 1'b1, 1'b0, 10'h2AA, 8'h0);
        @(posedge clkram); #2;
        cpu_req = 1'b0;
        reset = 1'b1;
        #1;
        check_zero();
        @(posedge clkram);
        @(posedge clkram);
        @(negedge clkram);
        reset = 1'b0;
        model_clear();
        idle(5);
        cpu_run(1'b0, 10'h2AA, 8'h00, 0);
        idle(1);
        check_eq("retry_rdata", 32'(cpu_rdata), 32'h5B);

        // abandoned request: one pending cycle under video, then dropped
        cycle(1'b1, 10'h100, 1'b1, 1'b0, 10'h200, 8'h0);
        idle(4);
        cpu_run(1'b0, 10'h200, 8'h00, 0);
        idle(1);
        check_eq("stall_max_abandon", 32'(stall_max), 32'd1);
        cpu_run(1'b0, 10'h201, 8'h00, 2);
        idle(1);
        check_eq("stall_cnt_cleared", 32'(stall_max), 32'd2);

        // randomised traffic
        cpu_active = 1'b0; cur_we = 1'b0; cur_addr = '0; cur_data = '0; start_cyc = 0;
        for (int n = 0; n < 1500; n++) begin
            if (!cpu_active) begin
                if ($urandom_range(0, 9) < 3) begin
                    cpu_active = 1'b1;
                    cur_we = 1'($urandom);
                    cur_addr = 10'($urandom);
                    cur_data = 8'($urandom);
                    start_cyc = cyc + 1;
                end
            end else if (last_cpu_grant < start_cyc && $urandom_range(0, 19) == 0) begin
                cpu_active = 1'b0;
            end
            cycle(1'($urandom_range(0, 9) < 4), 10'($urandom), cpu_active, cur_we, cur_addr, cur_data);
            if (model_ack) cpu_active = 1'b0;
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
